// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: initiator for a 2-bit-op combinational ALU.
// Takes commands over a valid/ready stream and drives the ALU operand/op ports.
// It captures the ALU result and returns it over a valid/ready response stream.
// The last captured result is kept as the accumulator, which later commands can
// use as operand A.
module alu_cmd_sequencer #(
  parameter int W     = 24,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [W-1:0]     cmd_a,
  input  logic [W-1:0]     cmd_b,
  input  logic             cmd_acc,
  output logic [1:0]       alu_op,
  output logic [W-1:0]     alu_a,
  output logic [W-1:0]     alu_b,
  input  logic [W-1:0]     alu_r,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [W-1:0]     rsp_data,
  output logic [W-1:0]     acc,
  output logic [CNT_W-1:0] op_count,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   accept;
  logic   capture;
  logic   retire;

  // State register; reset drops any in-flight command
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode plus handshake/strobe outputs
  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    busy      = 1'b1;
    accept    = 1'b0;
    capture   = 1'b0;
    retire    = 1'b0;
    case (state)
      IDLE: begin
        busy      = 1'b0;
        // held low while reset is asserted so nothing is offered during reset
        cmd_ready = rst_n;
        if (cmd_valid) begin
          accept    = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        // ALU operands have been stable all cycle; take the result at the edge
        capture   = 1'b1;
        state_nxt = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          retire    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ALU operand registers: loaded on accept, otherwise hold their last values
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_op <= '0;
      alu_a  <= '0;
      alu_b  <= '0;
    end else if (accept) begin
      alu_op <= cmd_op;
      alu_a  <= cmd_acc ? acc : cmd_a;
      alu_b  <= cmd_b;
    end
  end

  // Result capture into the response register and the accumulator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data <= '0;
      acc      <= '0;
    end else if (capture) begin
      rsp_data <= alu_r;
      acc      <= alu_r;
    end
  end

  // Response valid flag and completed-operation counter (wraps naturally)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      op_count  <= '0;
    end else if (capture) begin
      rsp_valid <= 1'b1;
    end else if (retire) begin
      rsp_valid <= 1'b0;
      op_count  <= op_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Testbench for alu_cmd_sequencer: directed steps followed by random commands.
// The results are checked against a behavioural model of the command stream.
module tb_alu_cmd_sequencer;

  localparam int W     = 24;
  localparam int CNT_W = 16;

  logic             clk;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [W-1:0]     cmd_a;
  logic [W-1:0]     cmd_b;
  logic             cmd_acc;
  logic [1:0]       alu_op;
  logic [W-1:0]     alu_a;
  logic [W-1:0]     alu_b;
  logic [W-1:0]     alu_r;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [W-1:0]     rsp_data;
  logic [W-1:0]     acc;
  logic [CNT_W-1:0] op_count;
  logic             busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [W-1:0] model_acc = '0;
  int           model_cnt = 0;

  alu_cmd_sequencer #(.W(W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_acc   (cmd_acc),
    .alu_op    (alu_op),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_r     (alu_r),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .acc       (acc),
    .op_count  (op_count),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ALU arithmetic as plain integer math: add/and/shr/shl, modulo 2^W
  function automatic logic [W-1:0] ref_alu(input logic [1:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    longint unsigned la, lb, m, r;
    la = longint'(a);
    lb = longint'(b);
    m  = 64'd1 << W;
    case (op)
      2'd0:    r = (la + lb) % m;
      2'd1:    r = la & lb;
      2'd2:    r = (lb >= W) ? 0 : (la >> lb);
      default: r = (lb >= W) ? 0 : ((la << lb) % m);
    endcase
    return r[W-1:0];
  endfunction

  // the external ALU the sequencer drives
  assign alu_r = ref_alu(alu_op, alu_a, alu_b);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one command, optionally stall the response, then retire it.
  // Called and returns at #1 after a rising edge.
  task automatic do_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic accf, input int stall);
    logic [W-1:0] ea, er;
    int n;
    ea = accf ? model_acc : a;
    er = ref_alu(op, ea, b);
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_acc = accf; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 20) begin @(posedge clk); #1; n++; end
    check("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_a = W'($urandom);
    cmd_b = W'($urandom);
    check("exec_alu_a", 32'(alu_a), 32'(ea));
    check("exec_alu_b", 32'(alu_b), 32'(b));
    check("exec_alu_op", 32'(alu_op), 32'(op));
    check("exec_busy", 32'(busy), 32'd1);
    check("exec_rsp_valid", 32'(rsp_valid), 32'd0);
    check("exec_cmd_ready", 32'(cmd_ready), 32'd0);
    @(posedge clk); #1;
    check("rsp_valid", 32'(rsp_valid), 32'd1);
    check("rsp_data", 32'(rsp_data), 32'(er));
    check("rsp_acc", 32'(acc), 32'(er));
    check("rsp_count_pre", 32'(op_count), 32'(model_cnt % (1 << CNT_W)));
    for (int s = 0; s < stall; s++) begin
      rsp_ready = 1'b0;
      @(posedge clk); #1;
      check("stall_rsp_valid", 32'(rsp_valid), 32'd1);
      check("stall_rsp_data", 32'(rsp_data), 32'(er));
      check("stall_alu_a", 32'(alu_a), 32'(ea));
      check("stall_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    model_cnt++;
    model_acc = er;
    check("done_rsp_valid", 32'(rsp_valid), 32'd0);
    check("done_count", 32'(op_count), 32'(model_cnt % (1 << CNT_W)));
    check("done_cmd_ready", 32'(cmd_ready), 32'd1);
    check("done_acc", 32'(acc), 32'(er));
  endtask

  initial begin
    logic [W-1:0] exp_r;
    logic [1:0]   rop;
    logic [W-1:0] ra, rb;
    int n, t, prev;

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0;
    cmd_acc = 1'b0; rsp_ready = 1'b0;
    #2;
    // reset state
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_acc", 32'(acc), 32'd0);
    check("rst_count", 32'(op_count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_alu_a", 32'(alu_a), 32'd0);
    check("rst_alu_b", 32'(alu_b), 32'd0);
    check("rst_alu_op", 32'(alu_op), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_cmd_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;

    // add, then accumulator chain (shl by 4 -> 128, and 0xF0 -> 0x80)
    do_op(2'd0, 24'd5, 24'd3, 1'b0, 0);
    check("t1_data", 32'(rsp_data), 32'd8);
    do_op(2'd3, 24'hABCDEF, 24'd4, 1'b1, 0);
    check("t2_shl", 32'(rsp_data), 32'd128);
    do_op(2'd1, 24'h123456, 24'hF0, 1'b1, 0);
    check("t2_and", 32'(rsp_data), 32'h80);

    // backpressure with a pending command waiting behind the response
    cmd_op = 2'd0; cmd_a = 24'd1; cmd_b = 24'd2; cmd_acc = 1'b0; cmd_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    cmd_op = 2'd1; cmd_a = 24'hFF; cmd_b = 24'h0F;
    rsp_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rsp_data", 32'(rsp_data), 32'd3);
      check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
      check("bp_alu_a", 32'(alu_a), 32'd1);
      check("bp_alu_b", 32'(alu_b), 32'd2);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("bp_hs_rsp_valid", 32'(rsp_valid), 32'd0);
    check("bp_hs_cmd_ready", 32'(cmd_ready), 32'd1);
    check("bp_hs_alu_a", 32'(alu_a), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("bp_next_alu_a", 32'(alu_a), 32'hFF);
    check("bp_next_alu_op", 32'(alu_op), 32'd1);
    @(posedge clk); #1;
    check("bp_next_data", 32'(rsp_data), 32'h0F);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    model_cnt += 2;
    model_acc = 24'h0F;
    check("bp_count", 32'(op_count), 32'(model_cnt));

    // boundaries: add wrap, shr by W-1, shl by W
    do_op(2'd0, 24'hFFFFFF, 24'd1, 1'b0, 1);
    check("b_add_wrap", 32'(rsp_data), 32'd0);
    do_op(2'd2, 24'h800000, 24'd23, 1'b0, 2);
    check("b_shr23", 32'(rsp_data), 32'd1);
    do_op(2'd3, 24'd1, 24'd24, 1'b0, 0);
    check("b_shl24", 32'(rsp_data), 32'd0);

    // reset asserted while executing
    cmd_op = 2'd0; cmd_a = 24'd7; cmd_b = 24'd7; cmd_acc = 1'b0; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("mr_busy_pre", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mr_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mr_acc", 32'(acc), 32'd0);
    check("mr_count", 32'(op_count), 32'd0);
    check("mr_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mr_cmd_ready", 32'(cmd_ready), 32'd1);
    for (int s = 0; s < 3; s++) begin
      @(posedge clk); #1;
      check("mr_no_stray", 32'(rsp_valid), 32'd0);
    end
    model_acc = '0;
    model_cnt = 0;

    // throughput: rsp_ready tied high, four commands back to back
    rsp_ready = 1'b1;
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      cmd_op = 2'(i); cmd_a = 24'h00F0F0 + W'(i); cmd_b = W'(i + 1); cmd_acc = 1'b0;
      exp_r = ref_alu(cmd_op, cmd_a, cmd_b);
      cmd_valid = 1'b1;
      n = 0;
      while (!cmd_ready && n < 20) begin @(posedge clk); #1; n++; end
      check("tp_ready_wait", 32'(cmd_ready), 32'd1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      @(posedge clk); #1;
      check("tp_rsp_valid", 32'(rsp_valid), 32'd1);
      check("tp_rsp_data", 32'(rsp_data), 32'(exp_r));
      t = cyc;
      if (i > 0) check("tp_spacing", 32'(t - prev), 32'd3);
      prev = t;
      model_cnt++;
      model_acc = exp_r;
    end
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("tp_count", 32'(op_count), 32'd4);

    // random commands against the model
    for (int i = 0; i < 25; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = W'($urandom);
      rb  = (rop >= 2) ? W'($urandom_range(0, 27)) : W'($urandom);
      do_op(rop, ra, rb, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
